// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write channel between
// NUM_CONSUMERS per-thread LSUs, with one outstanding transaction at a time.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_enable,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready,
  output logic                                busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]    grant
);

  localparam int GW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t                   state, state_nxt;
  logic [GW-1:0]            rr_ptr;
  logic [GW-1:0]            sel_idx;
  logic                     sel_found;
  logic                     op_read;
  logic                     relay_done;
  logic                     grant_last;
  logic [NUM_CONSUMERS-1:0] eligible;

  assign eligible   = consumer_enable & (consumer_read_valid | consumer_write_valid);
  assign relay_done = op_read ? !consumer_read_valid[grant] : !consumer_write_valid[grant];
  assign grant_last = (grant == GW'(NUM_CONSUMERS - 1));

  // First eligible consumer at or after rr_ptr, wrapping around.
  always_comb begin : scan_blk
    int            idx;
    logic [GW-1:0] cand;
    idx       = 0;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_CONSUMERS;
      cand = idx[GW-1:0];
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (sel_found) state_nxt = consumer_read_valid[sel_idx] ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  if (mem_read_ready) state_nxt = RELAY;
      WRITE_WAIT: if (mem_write_ready) state_nxt = RELAY;
      RELAY:      if (relay_done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Registered handshake and data outputs; reset clears everything so an
  // aborted transaction never produces a consumer ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr               <= '0;
      grant                <= '0;
      op_read              <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant <= sel_idx;
            if (consumer_read_valid[sel_idx]) begin
              op_read          <= 1'b1;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[sel_idx*ADDR_BITS +: ADDR_BITS];
            end else begin
              op_read           <= 1'b0;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[sel_idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[sel_idx*DATA_BITS +: DATA_BITS];
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                                 <= 1'b0;
            consumer_read_data[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant]                     <= 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
          end
        end
        RELAY: begin
          // Hold ready until the LSU withdraws its request, then rotate priority.
          if (relay_done) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            rr_ptr               <= grant_last ? '0 : grant + 1'b1;
            grant                <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: LSU and memory models plus a scoreboard
// of expected memory requests and consumer completions in grant order.
module tb_lsu_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  consumer_enable;
  logic [N-1:0]  consumer_read_valid, consumer_read_ready;
  logic [N-1:0]  consumer_write_valid, consumer_write_ready;
  logic [N*AW-1:0] consumer_read_address, consumer_write_address;
  logic [N*DW-1:0] consumer_read_data, consumer_write_data;
  logic          mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data, mem_write_data;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset), .consumer_enable(consumer_enable),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy), .grant(grant)
  );

  typedef struct {
    bit         wr;
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } txn_t;

  txn_t req_q[$];
  txn_t cmp_q[$];
  int   n_total = 0;
  int   n_fail  = 0;
  int   rd_lat  = 1;
  int   wr_lat  = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit wr, input int c, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.c = c; t.a = a; t.d = d;
    req_q.push_back(t);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(req_q.size() == 0 && cmp_q.size() == 0 && !busy) && k < budget);
    chk("idle_timeout", 32'(k >= budget), 0);
  endtask

  // Memory: ready after rd_lat/wr_lat cycles of valid; read data = addr ^ 0x46.
  initial begin : mem_model
    int rc;
    int wc;
    rc = 0; wc = 0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'hEE;
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 8'hEE;
      if (reset && mem_read_valid) begin
        rc++;
        if (rc >= rd_lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_read_address ^ 8'h46;
          rc = 0;
        end
      end else rc = 0;
      if (reset && mem_write_valid) begin
        wc++;
        if (wc >= wr_lat) begin
          mem_write_ready = 1'b1;
          wc = 0;
        end
      end else wc = 0;
    end
  end

  // LSU: drops valid on the cycle after it first sees ready.
  initial begin : lsu_model
    logic [N-1:0] rs;
    logic [N-1:0] ws;
    rs = '0; ws = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rs[i]) begin
          consumer_read_valid[i] = 1'b0;
          rs[i] = 1'b0;
        end else if (consumer_read_ready[i] && consumer_read_valid[i]) rs[i] = 1'b1;
        if (ws[i]) begin
          consumer_write_valid[i] = 1'b0;
          ws[i] = 1'b0;
        end else if (consumer_write_ready[i] && consumer_write_valid[i]) ws[i] = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic         pr, pw;
    logic [N-1:0] prr, pwr;
    int           hi;
    txn_t         t;
    pr = 1'b0; pw = 1'b0; prr = '0; pwr = '0; hi = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("mem_excl", 32'(mem_read_valid & mem_write_valid), 0);
        chk("rdy_onehot0", 32'($onehot0({consumer_read_ready, consumer_write_ready})), 1);
        if ((mem_read_valid && !pr) || (mem_write_valid && !pw)) begin
          if (req_q.size() == 0) chk("unexpected_req", 1, 0);
          else begin
            t = req_q.pop_front();
            chk("req_kind", 32'(mem_write_valid), 32'(t.wr));
            chk("req_grant", 32'(grant), t.c);
            if (t.wr) begin
              chk("wr_addr", 32'(mem_write_address), 32'(t.a));
              chk("wr_data", 32'(mem_write_data), 32'(t.d));
            end else chk("rd_addr", 32'(mem_read_address), 32'(t.a));
            cmp_q.push_back(t);
          end
        end
        if (((consumer_read_ready & ~prr) | (consumer_write_ready & ~pwr)) != '0) begin
          if (cmp_q.size() == 0) chk("unexpected_rdy", 1, 0);
          else begin
            t = cmp_q.pop_front();
            chk("rdy_vec", 32'(t.wr ? consumer_write_ready : consumer_read_ready), 1 << t.c);
            chk("rdy_other", 32'(t.wr ? consumer_read_ready : consumer_write_ready), 0);
            if (!t.wr) chk("rd_data", 32'(consumer_read_data[t.c*DW +: DW]), 32'(t.a ^ 8'h46));
          end
        end
        if ((consumer_read_ready | consumer_write_ready) != '0) hi++;
        else if (hi != 0) begin
          chk("rdy_len", hi, 2);
          hi = 0;
        end
      end else hi = 0;
      pr = mem_read_valid; pw = mem_write_valid;
      prr = consumer_read_ready; pwr = consumer_write_ready;
    end
  end

  initial begin : main
    reset = 1'b0;
    consumer_enable = '1;
    consumer_read_valid = '0; consumer_write_valid = '0;
    consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mrv", 32'(mem_read_valid), 0);
    chk("rst_mwv", 32'(mem_write_valid), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_rrdy", 32'(consumer_read_ready), 0);
    chk("rst_wrdy", 32'(consumer_write_ready), 0);
    chk("rst_rdata", consumer_read_data, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin: all four at once, then 0 and 3.
    for (int c = 0; c < N; c++) begin
      consumer_read_address[c*AW +: AW] = 8'h10 + 8'(c);
      push(1'b0, c, 8'h10 + 8'(c), 8'h00);
    end
    consumer_read_valid = 4'hF;
    wait_idle(200);
    for (int c = 0; c < N; c++)
      chk("rd_hold", 32'(consumer_read_data[c*DW +: DW]), 32'((8'h10 + 8'(c)) ^ 8'h46));
    consumer_read_address[0 +: AW]    = 8'h20;
    consumer_read_address[3*AW +: AW] = 8'h23;
    consumer_read_valid = 4'b1001;
    push(1'b0, 0, 8'h20, 8'h00);
    push(1'b0, 3, 8'h23, 8'h00);
    wait_idle(100);

    // Single read, 3-cycle memory.
    rd_lat = 3;
    consumer_read_address[2*AW +: AW] = 8'h1A;
    consumer_read_valid[2] = 1'b1;
    push(1'b0, 2, 8'h1A, 8'h00);
    @(posedge clk); #1;
    chk("lat_mrv", 32'(mem_read_valid), 1);
    chk("lat_busy", 32'(busy), 1);
    wait_idle(100);
    chk("rd_busy_end", 32'(busy), 0);
    rd_lat = 1;

    // Single write.
    consumer_write_address[0 +: AW] = 8'h03;
    consumer_write_data[0 +: DW]    = 8'h77;
    consumer_write_valid[0] = 1'b1;
    push(1'b1, 0, 8'h03, 8'h77);
    wait_idle(100);
    chk("wr_no_rrdy", 32'(consumer_read_ready), 0);

    // Masking and read-over-write priority.
    consumer_enable = 4'b1101;
    consumer_read_address[1*AW +: AW]  = 8'h31;
    consumer_write_address[1*AW +: AW] = 8'h41;
    consumer_write_data[1*DW +: DW]    = 8'h99;
    consumer_read_address[2*AW +: AW]  = 8'h32;
    consumer_read_valid[1] = 1'b1; consumer_write_valid[1] = 1'b1;
    consumer_read_valid[2] = 1'b1;
    push(1'b0, 2, 8'h32, 8'h00);
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("mask_busy", 32'(busy), 0);
    chk("mask_rv1", 32'(consumer_read_valid[1]), 1);
    chk("mask_wv1", 32'(consumer_write_valid[1]), 1);
    consumer_enable = 4'hF;
    push(1'b0, 1, 8'h31, 8'h00);
    push(1'b1, 1, 8'h41, 8'h99);
    wait_idle(200);

    // Stall: consumer 3 held in READ_WAIT while consumer 0 waits.
    rd_lat = 22;
    consumer_read_address[3*AW +: AW] = 8'h53;
    consumer_read_address[0 +: AW]    = 8'h50;
    consumer_read_valid[3] = 1'b1; consumer_read_valid[0] = 1'b1;
    push(1'b0, 3, 8'h53, 8'h00);
    push(1'b0, 0, 8'h50, 8'h00);
    @(posedge clk); #1;
    chk("stall_start", 32'(mem_read_valid), 1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("stall_mrv", 32'(mem_read_valid), 1);
      chk("stall_addr", 32'(mem_read_address), 32'h53);
      chk("stall_grant", 32'(grant), 3);
      chk("stall_rdy", 32'(consumer_read_ready), 0);
    end
    rd_lat = 1;
    wait_idle(200);

    // Reset mid READ_WAIT aborts immediately.
    rd_lat = 50;
    consumer_read_address[1*AW +: AW] = 8'h61;
    consumer_read_valid[1] = 1'b1;
    push(1'b0, 1, 8'h61, 8'h00);
    @(posedge clk); #1;
    chk("abort_pre", 32'(mem_read_valid), 1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_mrv", 32'(mem_read_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_rrdy", 32'(consumer_read_ready), 0);
    chk("abort_data", consumer_read_data, 0);
    consumer_read_valid = '0;
    req_q.delete();
    cmp_q.delete();
    @(negedge clk) reset = 1'b1;
    rd_lat = 1;
    @(negedge clk);

    // rr_ptr restarted at 0: consumer 0 before consumer 2.
    consumer_read_address[0 +: AW]    = 8'h70;
    consumer_read_address[2*AW +: AW] = 8'h72;
    consumer_read_valid[0] = 1'b1; consumer_read_valid[2] = 1'b1;
    push(1'b0, 0, 8'h70, 8'h00);
    push(1'b0, 2, 8'h72, 8'h00);
    wait_idle(100);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
